// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch front end: one-outstanding fetch FSM feeding a small FIFO, with redirect flush.
// Optional statistics counters enabled by defining IFETCH_STATS_EN.
module inst_prefetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exit,
  output logic        ireq_valid,
  input  logic        ireq_ready,
  output logic [31:0] ireq_addr,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_addr,
  input  logic [31:0] iresp_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_inst
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_dropped
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {ISSUE, WAIT_RESP, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        addr_mem_q [DEPTH];
  logic [31:0]        inst_mem_q [DEPTH];

  logic        accept, push, pop, drop, redir;
  logic [31:0] redir_pc;

  always_comb begin
    ireq_valid = (state_q == ISSUE) && (count_q < FULL_C) && !exit && !reset;
    ireq_addr  = pc_q;
    out_valid  = (count_q != '0) && !reset;
    out_addr   = addr_mem_q[rptr_q];
    out_inst   = inst_mem_q[rptr_q];
  end

  always_comb begin
    accept   = ireq_valid && ireq_ready;
    redir    = redirect_valid && !exit;
    redir_pc = redirect_pc & 32'hFFFF_FFFC;
    pop      = out_valid && out_ready && !redirect_valid && !exit;
    push     = 1'b0;
    drop     = 1'b0;
    state_d  = state_q;
    pc_d     = pc_q;
    if (!exit) begin
      case (state_q)
        ISSUE: begin
          if (accept) state_d = redirect_valid ? DRAIN : WAIT_RESP;
          if (redirect_valid) pc_d = redir_pc;
        end
        WAIT_RESP: begin
          if (iresp_valid) begin
            state_d = ISSUE;
            if (redirect_valid) begin
              drop = 1'b1;
              pc_d = redir_pc;
            end else begin
              push = 1'b1;
              pc_d = pc_q + 32'd4;
            end
          end else if (redirect_valid) begin
            state_d = DRAIN;
            pc_d    = redir_pc;
          end
        end
        DRAIN: begin
          // The outstanding response belongs to a flushed stream.
          if (iresp_valid) begin
            state_d = ISSUE;
            drop    = 1'b1;
          end
          if (redirect_valid) pc_d = redir_pc;
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (redir) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wptr_q] <= iresp_addr;
      inst_mem_q[wptr_q] <= iresp_inst;
    end
  end

`ifdef IFETCH_STATS_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] dropped_q, dropped_d;

  always_comb begin
    issued_d  = issued_q;
    dropped_d = dropped_q;
    if (accept && (issued_q != 32'hFFFF_FFFF)) issued_d = issued_q + 32'd1;
    if (drop && (dropped_q != 32'hFFFF_FFFF))  dropped_d = dropped_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      issued_q  <= issued_d;
      dropped_q <= dropped_d;
    end
  end

  assign stat_issued  = issued_q;
  assign stat_dropped = dropped_q;
`endif

endmodule
